// File: rtl/config_loader_if.sv
// rtl/config_loader_if.sv - word stream and latch-array bus between the bitstream source and config_loader
interface config_loader_if #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 41,
  parameter int IDX_WIDTH  = 6
);
  logic                  io_start;
  logic                  io_abort;
  logic                  io_in_valid;
  logic                  io_in_ready;
  logic [WORD_WIDTH-1:0] io_in_data;
  logic [WORD_WIDTH-1:0] io_d_out;
  logic [NUM_WORDS-1:0]  io_configs_en;
  logic [IDX_WIDTH-1:0]  io_word_idx;
  logic                  io_busy;
  logic                  io_done;

  modport master (
    output io_start, io_abort, io_in_valid, io_in_data,
    input  io_in_ready, io_d_out, io_configs_en, io_word_idx, io_busy, io_done
  );

  modport slave (
    input  io_start, io_abort, io_in_valid, io_in_data,
    output io_in_ready, io_d_out, io_configs_en, io_word_idx, io_busy, io_done
  );
endinterface

// File: rtl/config_loader.sv
// rtl/config_loader.sv - setup/pulse/hold write sequencer for the tile configuration latch array
module config_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 41,
  parameter int IDX_WIDTH  = 6
) (
  input logic            clk,
  input logic            reset,
  config_loader_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);
  localparam logic [NUM_WORDS-1:0] EN_ONE   = NUM_WORDS'(1);

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [WORD_WIDTH-1:0] d_out_q, d_out_d;
  logic [NUM_WORDS-1:0]  en_q, en_d;
  logic                  done_q, done_d;

  // Enables default low every cycle so only the SETUP->PULSE edge can raise one.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    d_out_d = d_out_q;
    en_d    = '0;
    done_d  = 1'b0;
    if (bus.io_abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.io_start) begin
            state_d = S_WAIT;
            idx_d   = '0;
          end
        end
        S_WAIT: begin
          if (bus.io_in_valid) begin
            d_out_d = bus.io_in_data;
            state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          en_d    = EN_ONE << idx_q;
          state_d = S_PULSE;
        end
        S_PULSE: state_d = S_HOLD;
        S_HOLD: begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            state_d = S_WAIT;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      d_out_q <= '0;
      en_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_out_q <= d_out_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign bus.io_d_out      = d_out_q;
  assign bus.io_configs_en = en_q;
  assign bus.io_done       = done_q;
  assign bus.io_word_idx   = idx_q;
  assign bus.io_in_ready   = (state_q == S_WAIT);
  assign bus.io_busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - directed self-checking bench for config_loader
module tb_config_loader;
  localparam int WW = 32;
  localparam int NW = 41;
  localparam int IW = 6;
  localparam int LOAD_EDGES = 4 * NW;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   pulse_count = 0;
  logic [WW-1:0] prev_d;
  logic [NW-1:0] prev_en;
  logic          prev_valid = 1'b0;

  config_loader_if #(.WORD_WIDTH(WW), .NUM_WORDS(NW), .IDX_WIDTH(IW)) bus ();

  config_loader #(.WORD_WIDTH(WW), .NUM_WORDS(NW), .IDX_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      checks++;
      if ($countones(bus.io_configs_en) > 1) begin
        errors++;
        $display("FAIL en_onehot: en=%h popcount=%0d, required <= 1", bus.io_configs_en, $countones(bus.io_configs_en));
      end
      if (bus.io_configs_en != '0) pulse_count++;
      if (prev_valid && (bus.io_configs_en != '0 || prev_en != '0)) begin
        checks++;
        if (bus.io_d_out !== prev_d) begin
          errors++;
          $display("FAIL d_stable: d_out=%h, required %h around enable pulse", bus.io_d_out, prev_d);
        end
      end
      prev_d     = bus.io_d_out;
      prev_en    = bus.io_configs_en;
      prev_valid = 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++; if (bus.io_d_out !== '0) begin errors++; $display("FAIL reset_d_out: got %h want 0", bus.io_d_out); end
    checks++; if (bus.io_configs_en !== '0) begin errors++; $display("FAIL reset_en: got %h want 0", bus.io_configs_en); end
    checks++; if (bus.io_word_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.io_word_idx); end
    checks++; if (bus.io_in_ready !== 1'b0 || bus.io_busy !== 1'b0 || bus.io_done !== 1'b0) begin
      errors++; $display("FAIL reset_flags: ready=%b busy=%b done=%b want 0 0 0", bus.io_in_ready, bus.io_busy, bus.io_done);
    end
    reset = 1'b0;
    tick;
    checks++; if (bus.io_busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b want 0", bus.io_busy); end
  endtask

  task automatic test_full_load;
    int k;
    logic [NW-1:0] exp_en;
    bus.io_in_valid = 1'b1;
    bus.io_in_data  = '0;
    bus.io_start    = 1'b1;
    tick;
    bus.io_start = 1'b0;
    pulse_count  = 0;
    // Counting the io_start cycle as cycle 1, done is seen in cycle 166.
    for (int n = 0; n <= LOAD_EDGES; n++) begin
      k = n / 4;
      checks++;
      if (n == LOAD_EDGES) begin
        if (bus.io_done !== 1'b1) begin errors++; $display("FAIL full_done: done=%b want 1", bus.io_done); end
      end else begin
        exp_en = (n % 4 == 2) ? (NW'(1) << k) : '0;
        if (bus.io_configs_en !== exp_en || bus.io_done !== 1'b0 || bus.io_busy !== 1'b1 ||
            bus.io_in_ready !== 1'(n % 4 == 0) || bus.io_word_idx !== IW'(k)) begin
          errors++;
          $display("FAIL full_cycle n=%0d: en=%h done=%b busy=%b ready=%b idx=%0d want en=%h done=0 busy=1 ready=%b idx=%0d",
                   n, bus.io_configs_en, bus.io_done, bus.io_busy, bus.io_in_ready, bus.io_word_idx,
                   exp_en, (n % 4 == 0), k);
        end
        if (n % 4 != 0) begin
          checks++;
          if (bus.io_d_out !== WW'(k)) begin errors++; $display("FAIL full_d_out n=%0d: got %h want %h", n, bus.io_d_out, k); end
        end
      end
      bus.io_in_data = WW'(k);
      tick;
    end
    checks++; if (bus.io_busy !== 1'b0 || bus.io_done !== 1'b0) begin
      errors++; $display("FAIL full_idle: busy=%b done=%b want 0 0", bus.io_busy, bus.io_done);
    end
    checks++; if (pulse_count !== NW) begin errors++; $display("FAIL full_pulses: got %0d want %0d", pulse_count, NW); end
    bus.io_in_valid = 1'b0;
  endtask

  task automatic test_valid_gaps;
    logic [WW-1:0] w;
    logic [NW-1:0] exp_en;
    bus.io_in_valid = 1'b0;
    bus.io_start    = 1'b1;
    tick;
    bus.io_start = 1'b0;
    pulse_count  = 0;
    for (int k = 0; k < NW; k++) begin
      w = (k % 2 == 1) ? 32'h5A5A5A5A : 32'hA5A5A5A5;
      for (int g = 0; g < (k * 7) % 4; g++) begin
        checks++;
        if (bus.io_in_ready !== 1'b1 || bus.io_configs_en !== '0 || bus.io_word_idx !== IW'(k)) begin
          errors++; $display("FAIL gap_stall k=%0d: ready=%b en=%h idx=%0d want 1 0 %0d", k, bus.io_in_ready, bus.io_configs_en, bus.io_word_idx, k);
        end
        tick;
      end
      checks++; if (bus.io_in_ready !== 1'b1) begin errors++; $display("FAIL gap_ready k=%0d: ready=%b want 1", k, bus.io_in_ready); end
      bus.io_in_valid = 1'b1;
      bus.io_in_data  = w;
      tick;
      bus.io_in_valid = 1'b0;
      bus.io_in_data  = ~w;
      checks++; if (bus.io_in_ready !== 1'b0 || bus.io_configs_en !== '0 || bus.io_d_out !== w) begin
        errors++; $display("FAIL gap_setup k=%0d: ready=%b en=%h d=%h want 0 0 %h", k, bus.io_in_ready, bus.io_configs_en, bus.io_d_out, w);
      end
      tick;
      exp_en = NW'(1) << k;
      checks++; if (bus.io_in_ready !== 1'b0 || bus.io_configs_en !== exp_en || bus.io_d_out !== w) begin
        errors++; $display("FAIL gap_pulse k=%0d: ready=%b en=%h d=%h want 0 %h %h", k, bus.io_in_ready, bus.io_configs_en, bus.io_d_out, exp_en, w);
      end
      tick;
      checks++; if (bus.io_in_ready !== 1'b0 || bus.io_configs_en !== '0 || bus.io_d_out !== w) begin
        errors++; $display("FAIL gap_hold k=%0d: ready=%b en=%h d=%h want 0 0 %h", k, bus.io_in_ready, bus.io_configs_en, bus.io_d_out, w);
      end
      tick;
    end
    checks++; if (bus.io_done !== 1'b1) begin errors++; $display("FAIL gap_done: done=%b want 1", bus.io_done); end
    tick;
    checks++; if (bus.io_busy !== 1'b0 || bus.io_done !== 1'b0) begin
      errors++; $display("FAIL gap_idle: busy=%b done=%b want 0 0", bus.io_busy, bus.io_done);
    end
    checks++; if (pulse_count !== NW) begin errors++; $display("FAIL gap_pulses: got %0d want %0d", pulse_count, NW); end
  endtask

  task automatic test_abort;
    bus.io_in_valid = 1'b1;
    bus.io_in_data  = '0;
    bus.io_start    = 1'b1;
    tick;
    bus.io_start = 1'b0;
    for (int n = 0; n < 30; n++) begin
      bus.io_in_data = (n / 4 == 7) ? 32'hDEADBEEF : WW'(n / 4);
      tick;
    end
    checks++; if (bus.io_configs_en !== (NW'(1) << 7) || bus.io_d_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL abort_pulse: en=%h d=%h want %h deadbeef", bus.io_configs_en, bus.io_d_out, NW'(1) << 7);
    end
    bus.io_abort = 1'b1;
    tick;
    bus.io_abort = 1'b0;
    checks++; if (bus.io_busy !== 1'b0 || bus.io_in_ready !== 1'b0 || bus.io_done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy=%b ready=%b done=%b want 0 0 0", bus.io_busy, bus.io_in_ready, bus.io_done);
    end
    checks++; if (bus.io_configs_en !== '0) begin errors++; $display("FAIL abort_en: got %h want 0", bus.io_configs_en); end
    checks++; if (bus.io_d_out !== 32'hDEADBEEF) begin errors++; $display("FAIL abort_d_keep: got %h want deadbeef", bus.io_d_out); end
    checks++; if (bus.io_word_idx !== '0) begin errors++; $display("FAIL abort_idx: got %0d want 0", bus.io_word_idx); end
    tick;
    checks++; if (bus.io_busy !== 1'b0 || bus.io_done !== 1'b0) begin
      errors++; $display("FAIL abort_stay: busy=%b done=%b want 0 0", bus.io_busy, bus.io_done);
    end
    bus.io_start = 1'b1;
    bus.io_abort = 1'b1;
    tick;
    bus.io_start = 1'b0;
    bus.io_abort = 1'b0;
    checks++; if (bus.io_busy !== 1'b0) begin errors++; $display("FAIL abort_over_start: busy=%b want 0", bus.io_busy); end
    bus.io_in_valid = 1'b0;
    bus.io_start    = 1'b1;
    tick;
    bus.io_start = 1'b0;
    checks++; if (bus.io_in_ready !== 1'b1 || bus.io_word_idx !== '0 || bus.io_busy !== 1'b1) begin
      errors++; $display("FAIL abort_restart: ready=%b idx=%0d busy=%b want 1 0 1", bus.io_in_ready, bus.io_word_idx, bus.io_busy);
    end
    bus.io_in_valid = 1'b1;
    bus.io_in_data  = 32'h12345678;
    bus.io_abort    = 1'b1;
    tick;
    bus.io_abort    = 1'b0;
    bus.io_in_valid = 1'b0;
    checks++; if (bus.io_busy !== 1'b0 || bus.io_d_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL abort_over_handshake: busy=%b d=%h want 0 deadbeef", bus.io_busy, bus.io_d_out);
    end
  endtask

  task automatic test_async_reset;
    bus.io_in_valid = 1'b1;
    bus.io_in_data  = '0;
    bus.io_start    = 1'b1;
    tick;
    bus.io_start = 1'b0;
    for (int n = 0; n < 81; n++) begin
      bus.io_in_data = WW'(n / 4) + 32'h100;
      tick;
    end
    checks++; if (bus.io_d_out !== 32'h114 || bus.io_configs_en !== '0 || bus.io_busy !== 1'b1) begin
      errors++; $display("FAIL areset_setup: d=%h en=%h busy=%b want 114 0 1", bus.io_d_out, bus.io_configs_en, bus.io_busy);
    end
    #1;
    reset = 1'b1;
    #2;
    checks++; if (bus.io_d_out !== '0) begin errors++; $display("FAIL areset_d_out: got %h want 0", bus.io_d_out); end
    checks++; if (bus.io_configs_en !== '0 || bus.io_busy !== 1'b0 || bus.io_in_ready !== 1'b0 || bus.io_word_idx !== '0) begin
      errors++; $display("FAIL areset_outputs: en=%h busy=%b ready=%b idx=%0d want 0 0 0 0", bus.io_configs_en, bus.io_busy, bus.io_in_ready, bus.io_word_idx);
    end
    tick;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (bus.io_busy !== 1'b0 || bus.io_configs_en !== '0) begin
        errors++; $display("FAIL areset_hold_idle i=%0d: busy=%b en=%h want 0 0", i, bus.io_busy, bus.io_configs_en);
      end
    end
    bus.io_in_valid = 1'b0;
  endtask

  task automatic test_start_ignored;
    bus.io_in_valid = 1'b1;
    bus.io_in_data  = '0;
    bus.io_start    = 1'b1;
    tick;
    bus.io_start = 1'b0;
    // Stray io_start in WAIT of word 2 (n=8) and in HOLD of word 4 (n=19).
    for (int n = 0; n <= LOAD_EDGES; n++) begin
      checks++;
      if (n == LOAD_EDGES) begin
        if (bus.io_done !== 1'b1) begin errors++; $display("FAIL start_ign_done: done=%b want 1", bus.io_done); end
      end else if (bus.io_word_idx !== IW'(n / 4) || bus.io_busy !== 1'b1 || bus.io_done !== 1'b0) begin
        errors++; $display("FAIL start_ign_cycle n=%0d: idx=%0d busy=%b done=%b want %0d 1 0", n, bus.io_word_idx, bus.io_busy, bus.io_done, n / 4);
      end
      bus.io_start   = (n == 8 || n == 19);
      bus.io_in_data = WW'(n / 4) ^ 32'hFFFF0000;
      tick;
    end
    bus.io_start    = 1'b0;
    bus.io_in_valid = 1'b0;
    checks++; if (bus.io_busy !== 1'b0 || bus.io_done !== 1'b0) begin
      errors++; $display("FAIL start_ign_idle: busy=%b done=%b want 0 0", bus.io_busy, bus.io_done);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.io_start    = 1'b0;
    bus.io_abort    = 1'b0;
    bus.io_in_valid = 1'b0;
    bus.io_in_data  = '0;
    test_reset;
    test_full_load;
    test_valid_gaps;
    test_abort;
    test_async_reset;
    test_start_ignored;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded 1 ms, required to finish earlier");
    $fatal(1, "timeout");
  end
endmodule
